usb_host_receiver: RTL and testbench
====================================

Name: usb_host_receiver

Overview:
- Host-side receiver for the game-controller link; the far end of the controller's serial and parallel output lanes.
- Serial path: deserialises 8-bit frames on two lanes, coordinate and operation.
- Parallel path: latches one-cycle parallel words.
- For every committed frame: updates the current X/Y position and operation code, and reconstructs the controller's direction and button events as one-cycle pulses.
- Feeds host-side cursor and action logic.

Parameters:
- X_INIT, 4'hA, X position after reset.
- Y_INIT, 4'h8, Y position after reset.
- CHECK_OPS, 1, 1 enables operation-code and direction validation (frame_err); 0 disables both checks.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- rx_valid  in  1  serial frame qualifier; high for exactly 8 consecutive cycles per frame.
- rx_coord  in  1  serial coordinate lane; bits 0-3 are X[3:0] MSB first, bits 4-7 are Y[3:0] MSB first.
- rx_op  in  1  serial operation lane; bits 0-3 are op[3:0] MSB first, bits 4-7 must be 0.
- par_valid  in  1  parallel word strobe, one cycle.
- par_coord  in  8  parallel coordinate; [7:4] is X, [3:0] is Y.
- par_op  in  4  parallel operation code.
- x_pos  out  4  current X, held between frames.
- y_pos  out  4  current Y, held between frames.
- op_code  out  4  last committed operation code, held between frames.
- dir  out  4  one-hot direction pulse: [3]=L, [2]=R, [1]=U, [0]=D.
- btn  out  4  one-hot button pulse: [3]=A, [2]=B, [1]=X, [0]=Y.
- frame_done  out  1  one-cycle pulse marking a committed frame.
- frame_err  out  1  one-cycle pulse marking a protocol or validation error.

Behaviour:
- Reset values: x_pos=X_INIT, y_pos=Y_INIT, op_code=0, dir=0, btn=0, frame_done=0, frame_err=0, state=IDLE, bit counter=0, shift registers=0.
- A reset asserted mid-frame discards the partial frame immediately.

FSM states: IDLE, SHIFT, COMMIT.
- IDLE, rx_valid=1: sample bit 0 of both lanes, count=1, go to SHIFT.
- IDLE, rx_valid=0 and par_valid=1: latch par_coord/par_op, go to COMMIT.
- IDLE, rx_valid=1 and par_valid=1 together: serial wins; the parallel word is dropped.
- SHIFT, rx_valid=1: shift both lanes (new bit enters the LSB), count+1; after the 8th sample go to COMMIT.
- SHIFT, rx_valid=0 before 8 bits: frame_err pulse, return to IDLE, outputs unchanged.
- SHIFT: par_valid is ignored.
- COMMIT: lasts one cycle; ignores rx_valid and par_valid; returns to IDLE.

Timing:
- The bit sampled on edge k (k=0..7) is frame bit k.
- On edge 8 (leaving COMMIT): x_pos, y_pos, op_code update and frame_done=1, visible for exactly one cycle; dir and btn pulse in the same cycle.
- Back-to-back frames: the next rx_valid is accepted in IDLE, i.e. 2 cycles after the previous 8th bit. Earlier assertion is the sender's violation; bits arriving in COMMIT are lost.
- Parallel latency: par_valid at edge n gives outputs at edge n+1.

Operation decode:
- op 9 → btn A; B → btn B; D → btn X; F → btn Y.
- op 0 → move frame, no btn pulse.
- Any other op value, or serial op bits 4-7 nonzero (CHECK_OPS=1): frame_err pulse together with frame_done, op_code still updated, btn=0.

Direction decode (mod-16, compared with the previous x_pos/y_pos):
- X-1 → L; X+1 → R; Y+1 → U; Y-1 → D. Wrap is legal: 0→F is L, F→0 is R.
- No change → dir=0.
- Both axes changed, or |delta|>1 on either axis: dir=0 and frame_err pulse (CHECK_OPS=1); the new coordinates are still committed.
- CHECK_OPS=0: frame_err fires only for a short serial frame.

Decomposition:
- Shared package usb_ctrl_pkg holds: state encoding; op-code constants OP_A=4'h9, OP_B=4'hB, OP_X=4'hD, OP_Y=4'hF; X_INIT/Y_INIT defaults; dir/btn bit indices.
- Sub-module usb_rx_shift: dual-lane 8-bit shift register with 3-bit counter; outputs full, cnt, coord_sr, op_sr.
- The FSM, decode and validation logic stay in the top module.

Test Plan:
- Reset, then serial frame coord=1011_1000, op=1001_0000 → edge 8: x_pos=B, y_pos=8, op_code=9, dir=0100 (R), btn=1000 (A), frame_done=1 for one cycle, frame_err=0.
- From x=0, y=8, serial frame coord=1111_1000, op=0000_0000 → x_pos=F, dir=1000 (L, wrap), btn=0, no error.
- rx_valid high for 5 cycles then low → frame_err one-cycle pulse, no frame_done, x_pos/y_pos/op_code unchanged.
- par_valid with par_coord=8'hA9, par_op=4'hD → next edge: x_pos=A, y_pos=9, dir=0010 (U), btn=0010 (X), frame_done=1.
- Serial frame with op=0110_0000 → frame_done=1, frame_err=1, op_code=6, btn=0; then a frame with x and y both changed → dir=0, frame_err=1, coordinates committed.
- reset asserted on bit 4 of a frame, released, then a full valid frame → outputs return to A/8/0 immediately, and the following frame decodes correctly from bit 0.

Source files
------------

// File: rtl/usb_ctrl_pkg.sv
// Shared definitions for the game-controller link: FSM states, operation codes,
// reset positions and direction/button bit positions.
package usb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_e;

    localparam logic [3:0] OP_MOVE = 4'h0;
    localparam logic [3:0] OP_A    = 4'h9;
    localparam logic [3:0] OP_B    = 4'hB;
    localparam logic [3:0] OP_X    = 4'hD;
    localparam logic [3:0] OP_Y    = 4'hF;

    localparam logic [3:0] X_INIT_DEF = 4'hA;
    localparam logic [3:0] Y_INIT_DEF = 4'h8;

    localparam int unsigned DIR_L = 3;
    localparam int unsigned DIR_R = 2;
    localparam int unsigned DIR_U = 1;
    localparam int unsigned DIR_D = 0;

    localparam int unsigned BTN_A = 3;
    localparam int unsigned BTN_B = 2;
    localparam int unsigned BTN_X = 1;
    localparam int unsigned BTN_Y = 0;

endpackage

// File: rtl/usb_rx_shift.sv
// Dual-lane 8-bit deserialiser with sample counter; also accepts a parallel
// word so that both paths commit from the same registers.
module usb_rx_shift (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       shift_i,
    input  logic       load_i,
    input  logic       coord_bit_i,
    input  logic       op_bit_i,
    input  logic [7:0] par_coord_i,
    input  logic [3:0] par_op_i,
    output logic       full_o,
    output logic [2:0] cnt_o,
    output logic [7:0] coord_sr_o,
    output logic [7:0] op_sr_o
);

    logic [2:0] cnt_q;
    logic [7:0] coord_q;
    logic [7:0] op_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            coord_q <= '0;
            op_q    <= '0;
        end else if (load_i) begin
            // Parallel op lands in the serial op position; its pad bits are zero.
            coord_q <= par_coord_i;
            op_q    <= {par_op_i, 4'h0};
            cnt_q   <= '0;
        end else if (start_i) begin
            coord_q <= {7'b0, coord_bit_i};
            op_q    <= {7'b0, op_bit_i};
            cnt_q   <= 3'd1;
        end else if (shift_i) begin
            coord_q <= {coord_q[6:0], coord_bit_i};
            op_q    <= {op_q[6:0], op_bit_i};
            cnt_q   <= cnt_q + 3'd1;
        end
    end

    assign full_o     = (cnt_q == 3'd7);
    assign cnt_o      = cnt_q;
    assign coord_sr_o = coord_q;
    assign op_sr_o    = op_q;

endmodule

// File: rtl/usb_host_receiver.sv
// Host-side receiver: frame FSM, operation/direction decode and validation,
// held position registers and one-cycle event pulses.
module usb_host_receiver
    import usb_ctrl_pkg::*;
#(
    parameter logic [3:0] X_INIT    = X_INIT_DEF,
    parameter logic [3:0] Y_INIT    = Y_INIT_DEF,
    parameter bit         CHECK_OPS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic       rx_coord,
    input  logic       rx_op,
    input  logic       par_valid,
    input  logic [7:0] par_coord,
    input  logic [3:0] par_op,
    output logic [3:0] x_pos,
    output logic [3:0] y_pos,
    output logic [3:0] op_code,
    output logic [3:0] dir,
    output logic [3:0] btn,
    output logic       frame_done,
    output logic       frame_err
);

    state_e     state_q, state_d;
    logic       start, shift, load, abort;
    logic       full;
    logic [2:0] cnt;
    logic [7:0] coord_sr, op_sr;

    logic [3:0] x_q, x_d, y_q, y_d, op_q, op_d, dir_q, dir_d, btn_q, btn_d;
    logic       done_q, done_d, err_q, err_d;
    logic [3:0] new_x, new_y, new_op, dx, dy, dir_dec, btn_dec;
    logic       move_bad, op_bad, pad_bad;

    usb_rx_shift u_shift (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .shift_i     (shift),
        .load_i      (load),
        .coord_bit_i (rx_coord),
        .op_bit_i    (rx_op),
        .par_coord_i (par_coord),
        .par_op_i    (par_op),
        .full_o      (full),
        .cnt_o       (cnt),
        .coord_sr_o  (coord_sr),
        .op_sr_o     (op_sr)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        shift   = 1'b0;
        load    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    start   = 1'b1;
                    state_d = ST_SHIFT;
                end else if (par_valid) begin
                    load    = 1'b1;
                    state_d = ST_COMMIT;
                end
            end
            ST_SHIFT: begin
                if (rx_valid) begin
                    shift = 1'b1;
                    if (full) state_d = ST_COMMIT;
                end else begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Deltas are mod-16, so wrap-around steps decode like any other single step.
    always_comb begin
        new_x    = coord_sr[7:4];
        new_y    = coord_sr[3:0];
        new_op   = op_sr[7:4];
        pad_bad  = |op_sr[3:0];
        dx       = new_x - x_q;
        dy       = new_y - y_q;
        dir_dec  = '0;
        move_bad = 1'b0;
        if (dy == 4'h0) begin
            case (dx)
                4'h0:    ;
                4'h1:    dir_dec[DIR_R] = 1'b1;
                4'hF:    dir_dec[DIR_L] = 1'b1;
                default: move_bad = 1'b1;
            endcase
        end else if (dx == 4'h0) begin
            case (dy)
                4'h1:    dir_dec[DIR_U] = 1'b1;
                4'hF:    dir_dec[DIR_D] = 1'b1;
                default: move_bad = 1'b1;
            endcase
        end else begin
            move_bad = 1'b1;
        end

        btn_dec = '0;
        op_bad  = 1'b0;
        case (new_op)
            OP_A:    btn_dec[BTN_A] = 1'b1;
            OP_B:    btn_dec[BTN_B] = 1'b1;
            OP_X:    btn_dec[BTN_X] = 1'b1;
            OP_Y:    btn_dec[BTN_Y] = 1'b1;
            OP_MOVE: ;
            default: op_bad = 1'b1;
        endcase
        if (CHECK_OPS && pad_bad) btn_dec = '0;
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        op_d   = op_q;
        dir_d  = '0;
        btn_d  = '0;
        done_d = 1'b0;
        err_d  = abort;
        if (state_q == ST_COMMIT) begin
            x_d    = new_x;
            y_d    = new_y;
            op_d   = new_op;
            dir_d  = dir_dec;
            btn_d  = btn_dec;
            done_d = 1'b1;
            err_d  = CHECK_OPS && (move_bad || op_bad || pad_bad);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= X_INIT;
            y_q     <= Y_INIT;
            op_q    <= '0;
            dir_q   <= '0;
            btn_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            btn_q   <= btn_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign op_code    = op_q;
    assign dir        = dir_q;
    assign btn        = btn_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_usb_host_receiver.sv
// Bench for usb_host_receiver: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_usb_host_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid, rx_coord, rx_op, par_valid;
    logic [7:0] par_coord;
    logic [3:0] par_op;
    logic [3:0] x_pos, y_pos, op_code, dir, btn;
    logic       frame_done, frame_err;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_x, exp_y, exp_op, exp_dir, exp_btn;
    logic       exp_done, exp_err;

    usb_host_receiver #(.X_INIT(4'hA), .Y_INIT(4'h8), .CHECK_OPS(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_coord   (rx_coord),
        .rx_op      (rx_op),
        .par_valid  (par_valid),
        .par_coord  (par_coord),
        .par_op     (par_op),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .op_code    (op_code),
        .dir        (dir),
        .btn        (btn),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("x_pos",      {4'h0, x_pos},     {4'h0, exp_x});
        check("y_pos",      {4'h0, y_pos},     {4'h0, exp_y});
        check("op_code",    {4'h0, op_code},   {4'h0, exp_op});
        check("dir",        {4'h0, dir},       {4'h0, exp_dir});
        check("btn",        {4'h0, btn},       {4'h0, exp_btn});
        check("frame_done", {7'h0, frame_done}, {7'h0, exp_done});
        check("frame_err",  {7'h0, frame_err},  {7'h0, exp_err});
    end

    task automatic model_reset();
        exp_x = 4'hA; exp_y = 4'h8; exp_op = 4'h0;
        exp_dir = '0; exp_btn = '0; exp_done = 1'b0; exp_err = 1'b0;
    endtask

    // Frame-level reference: what a committed frame must produce.
    task automatic model_commit(input int nx, input int ny, input int op, input int pad);
        int dxm, dym;
        bit bad;
        dxm = (nx - int'(exp_x) + 16) % 16;
        dym = (ny - int'(exp_y) + 16) % 16;
        bad = 0;
        exp_dir = '0;
        if (dxm == 0 && dym == 0) exp_dir = '0;
        else if (dym == 0 && dxm == 15) exp_dir = 4'b1000;
        else if (dym == 0 && dxm == 1)  exp_dir = 4'b0100;
        else if (dxm == 0 && dym == 1)  exp_dir = 4'b0010;
        else if (dxm == 0 && dym == 15) exp_dir = 4'b0001;
        else bad = 1;
        exp_btn = '0;
        if (pad != 0) bad = 1;
        else if (op == 9)  exp_btn = 4'b1000;
        else if (op == 11) exp_btn = 4'b0100;
        else if (op == 13) exp_btn = 4'b0010;
        else if (op == 15) exp_btn = 4'b0001;
        else if (op != 0)  bad = 1;
        exp_x = 4'(nx); exp_y = 4'(ny); exp_op = 4'(op);
        exp_done = 1'b1;
        exp_err  = bad;
    endtask

    task automatic cycle(input logic rv, input logic rc, input logic ro, input logic pv,
                         input logic [7:0] pc, input logic [3:0] po);
        rx_valid = rv; rx_coord = rc; rx_op = ro;
        par_valid = pv; par_coord = pc; par_op = po;
        @(posedge clk);
        #1;
        exp_dir = '0; exp_btn = '0; exp_done = 1'b0; exp_err = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    endtask

    task automatic send_serial(input logic [7:0] c, input logic [7:0] o, input bit noise);
        for (int k = 0; k < 8; k++)
            cycle(1'b1, c[7-k], o[7-k], noise ? 1'($urandom) : 1'b0, 8'($urandom), 4'($urandom));
        cycle(1'b0, 1'($urandom), 1'($urandom), noise ? 1'($urandom) : 1'b0, 8'($urandom), 4'($urandom));
        model_commit(int'(c[7:4]), int'(c[3:0]), int'(o[7:4]), int'(o[3:0]));
    endtask

    task automatic send_par(input logic [7:0] c, input logic [3:0] o, input bit noise);
        cycle(1'b0, 1'($urandom), 1'($urandom), 1'b1, c, o);
        cycle(1'b0, 1'b0, 1'b0, noise ? 1'($urandom) : 1'b0, 8'($urandom), 4'($urandom));
        model_commit(int'(c[7:4]), int'(c[3:0]), int'(o), 0);
    endtask

    task automatic send_short(input int n);
        for (int k = 0; k < n; k++)
            cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom));
        cycle(1'b0, 1'b0, 1'b0, 1'($urandom), 8'($urandom), 4'($urandom));
        exp_err = 1'b1;
    endtask

    function automatic logic [3:0] pick_op();
        logic [3:0] ops [5];
        ops[0] = 4'h0; ops[1] = 4'h9; ops[2] = 4'hB; ops[3] = 4'hD; ops[4] = 4'hF;
        if ($urandom_range(0, 5) == 0) return 4'($urandom);
        return ops[$urandom_range(0, 4)];
    endfunction

    function automatic logic [7:0] pick_coord();
        logic [3:0] nx, ny;
        int kind;
        nx = exp_x; ny = exp_y;
        kind = $urandom_range(0, 9);
        case (kind)
            0:       begin nx = 4'($urandom); ny = 4'($urandom); end
            1:       ;
            2:       nx = nx + 4'h2;
            3, 4:    nx = nx + (($urandom_range(0, 1) == 1) ? 4'h1 : 4'hF);
            default: ny = ny + (($urandom_range(0, 1) == 1) ? 4'h1 : 4'hF);
        endcase
        return {nx, ny};
    endfunction

    initial begin
        rx_valid = 1'b0; rx_coord = 1'b0; rx_op = 1'b0;
        par_valid = 1'b0; par_coord = '0; par_op = '0;
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset x literal",  {4'h0, x_pos},   8'h0A);
        check("reset y literal",  {4'h0, y_pos},   8'h08);
        check("reset op literal", {4'h0, op_code}, 8'h00);
        reset = 1'b0;
        idle();

        send_serial(8'b1011_1000, 8'b1001_0000, 1'b0);
        check("t1 x literal",   {4'h0, x_pos},   8'h0B);
        check("t1 y literal",   {4'h0, y_pos},   8'h08);
        check("t1 op literal",  {4'h0, op_code}, 8'h09);
        check("t1 dir literal", {4'h0, dir},     8'h04);
        check("t1 btn literal", {4'h0, btn},     8'h08);
        check("t1 done literal", {7'h0, frame_done}, 8'h01);
        check("t1 err literal",  {7'h0, frame_err},  8'h00);
        idle();
        check("t1 done drop literal", {7'h0, frame_done}, 8'h00);

        send_par(8'h08, 4'h0, 1'b0);
        idle();
        send_serial(8'b1111_1000, 8'b0000_0000, 1'b0);
        check("t2 x literal",   {4'h0, x_pos}, 8'h0F);
        check("t2 dir literal", {4'h0, dir},   8'h08);
        check("t2 btn literal", {4'h0, btn},   8'h00);
        check("t2 err literal", {7'h0, frame_err}, 8'h00);

        send_short(5);
        check("t3 err literal",  {7'h0, frame_err},  8'h01);
        check("t3 done literal", {7'h0, frame_done}, 8'h00);
        check("t3 x literal",    {4'h0, x_pos},      8'h0F);
        idle();

        send_par(8'hA8, 4'h0, 1'b0);
        send_par(8'hA9, 4'hD, 1'b0);
        check("t4 x literal",   {4'h0, x_pos}, 8'h0A);
        check("t4 y literal",   {4'h0, y_pos}, 8'h09);
        check("t4 dir literal", {4'h0, dir},   8'h02);
        check("t4 btn literal", {4'h0, btn},   8'h02);
        check("t4 done literal", {7'h0, frame_done}, 8'h01);

        send_serial(8'hA9, 8'b0110_0000, 1'b0);
        check("t5 err literal", {7'h0, frame_err}, 8'h01);
        check("t5 op literal",  {4'h0, op_code},   8'h06);
        check("t5 btn literal", {4'h0, btn},       8'h00);
        send_serial(8'hBA, 8'h00, 1'b0);
        check("t5b dir literal", {4'h0, dir},       8'h00);
        check("t5b err literal", {7'h0, frame_err}, 8'h01);
        check("t5b xy literal",  {x_pos, y_pos},    8'hBA);

        for (int k = 0; k < 4; k++)
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'h0);
        reset = 1'b1;
        #1;
        model_reset();
        check("t6 reset xy literal", {x_pos, y_pos}, 8'hA8);
        check("t6 reset op literal", {4'h0, op_code}, 8'h00);
        idle();
        reset = 1'b0;
        send_serial(8'hB8, 8'hB0, 1'b0);
        check("t6 frame xy literal", {x_pos, y_pos}, 8'hB8);
        check("t6 frame btn literal", {4'h0, btn},   8'h04);

        for (int t = 0; t < 400; t++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                logic [7:0] o;
                o = {pick_op(), ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0};
                send_serial(pick_coord(), o, 1'b1);
            end else if (kind < 8) begin
                send_par(pick_coord(), pick_op(), 1'b1);
            end else begin
                send_short($urandom_range(1, 7));
            end
            repeat ($urandom_range(0, 2)) idle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
